// File: rtl/game_pkg.sv
// Shared types and constants for the tug-of-war game blocks.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } presser_state_t;

    localparam int              LFSR_W       = 10;
    localparam int              LFSR_TAP_HI  = 9;
    localparam int              LFSR_TAP_LO  = 6;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 10'h001;

endpackage

// File: rtl/cyber_lfsr.sv
// Free-running 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1 (period 1023).
module cyber_lfsr
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/cyber_presser.sv
// Computer opponent: issues random press/release waveforms, one rising edge per press.
//
//  state | meaning
//  IDLE  | waiting; compares lfsr against difficulty each cycle
//  PRESS | press held high for HOLD_CYC cycles (cut short when enable drops)
//  GAP   | press held low for GAP_CYC cycles, enable ignored
module cyber_presser
    import game_pkg::*;
#(
    parameter int                HOLD_CYC = 2,
    parameter int                GAP_CYC  = 2,
    parameter logic [LFSR_W-1:0] SEED     = SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] difficulty,
    output logic       press,
    output logic       busy,
    output logic [7:0] press_count
);

    localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);

    presser_state_t    state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic              hit;
    logic              count_inc;

    cyber_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign hit = enable && (lfsr < {1'b0, difficulty});

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        count_inc = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_nxt = PRESS;
                    cnt_nxt   = HOLD_LD;
                    count_inc = 1'b1;
                end
            end
            PRESS: begin
                // Dropping enable releases early so a finished round never leaves the key down.
                if (!enable || cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            press       <= 1'b0;
            busy        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= (state_nxt == PRESS);
            busy  <= (state_nxt != IDLE);
            if (count_inc && press_count != 8'hFF) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule
